alu_serial_ctrl: RTL and testbench



---
 rtl/alu_serial_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU slice, LSB first, for WIDTH cycles.
// Optional macro SLT_OVF_FIX_EN: overflow-corrected signed compare for SLT.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic [2:0]       slice_signal,
    output logic             slice_cin,
    input  logic             slice_dout,
    input  logic             slice_cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic [2:0]         w_op_legal;
    logic               w_set;
    logic [WIDTH-1:0]   w_res_final;
    logic [WIDTH-1:0]   w_result;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_res;
    logic [2:0]         r_op;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_dout;
    logic               r_zero;
`ifdef SLT_OVF_FIX_EN
    logic               r_cin_msb;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign dataOut = r_dout;
    assign zero    = r_zero;

    assign w_last = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // Unsupported op codes fall back to ADD
    always_comb begin
        w_op_legal = OP_ADD;
        case (signal)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: w_op_legal = signal;
            default:                               w_op_legal = OP_ADD;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        slice_a      = 1'b0;
        slice_b      = 1'b0;
        slice_signal = 3'b000;
        slice_cin    = 1'b0;
        if (r_state == S_RUN) begin
            slice_a      = r_a[0];
            slice_b      = r_b[0];
            slice_signal = r_op;
            slice_cin    = r_carry;
        end
    end

    // Result bits enter at the MSB and shift down, so after WIDTH bits bit 0 is the first one computed
    assign w_res_final = {slice_dout, r_res};

`ifdef SLT_OVF_FIX_EN
    assign w_set = slice_dout ^ r_cin_msb ^ slice_cout;
`else
    assign w_set = slice_dout;
`endif

    assign w_result = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_set} : w_res_final;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_op    <= 3'b000;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a     <= dataA;
                r_b     <= dataB;
                r_op    <= w_op_legal;
                r_carry <= w_op_legal[2];
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_res   <= w_res_final[WIDTH-1:1];
                r_carry <= slice_cout;
                if (w_last) begin
                    r_dout <= w_result;
                    r_zero <= (w_result == '0);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef SLT_OVF_FIX_EN
    // Carry out of bit WIDTH-2 is the carry into the MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cin_msb <= 1'b0;
        end else if ((r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 2))) begin
            r_cin_msb <= slice_cout;
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed testbench for alu_serial_ctrl with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;
    logic        zero;
    logic        slice_a;
    logic        slice_b;
    logic [2:0]  slice_signal;
    logic        slice_cin;
    logic        slice_dout;
    logic        slice_cout;
    logic        sl_bx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .signal       (signal),
        .dataA        (dataA),
        .dataB        (dataB),
        .busy         (busy),
        .done         (done),
        .dataOut      (dataOut),
        .zero         (zero),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_signal (slice_signal),
        .slice_cin    (slice_cin),
        .slice_dout   (slice_dout),
        .slice_cout   (slice_cout)
    );

    // Slice: B inverted for SUB/SLT, full adder for arithmetic codes
    assign sl_bx = slice_b ^ slice_signal[2];
    always_comb begin
        slice_dout = 1'b0;
        slice_cout = 1'b0;
        case (slice_signal)
            3'b000:  slice_dout = slice_a & slice_b;
            3'b001:  slice_dout = slice_a | slice_b;
            default: begin
                slice_dout = slice_a ^ sl_bx ^ slice_cin;
                slice_cout = (slice_a & sl_bx) | (slice_cin & (slice_a ^ sl_bx));
            end
        endcase
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          output logic [31:0] res, output logic z, output int nbusy,
                          output int lat, output logic [2:0] sig0, output logic cin0);
        @(negedge clk);
        start = 1'b1; dataA = a; dataB = b; signal = op;
        @(negedge clk);
        start = 1'b0; dataA = ~a; dataB = ~b; signal = 3'b001;
        sig0 = slice_signal;
        cin0 = slice_cin;
        lat = 1;
        nbusy = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        res = dataOut;
        z = zero;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL op_timeout: done=%b after %0d cycles, required 1", done, lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_with_done: got %b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; signal = 3'b000; dataA = '0; dataB = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, zero} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/zero=%b required 001", {busy, done, zero});
        end
        checks++;
        if (dataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_dataOut: got %h required 00000000", dataOut);
        end
        checks++;
        if ({slice_a, slice_b, slice_signal, slice_cin} !== 6'b0) begin
            errors++;
            $display("FAIL reset_slice: got %b required 000000", {slice_a, slice_b, slice_signal, slice_cin});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [31:0] res; logic z; int nb; int lat; logic [2:0] s0; logic c0;
        run_op(32'd5, 32'd7, 3'b010, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'h0000000C || z !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got %h zero=%b required 0000000c zero=0", res, z);
        end
        checks++;
        if (nb !== 32 || lat !== 33) begin
            errors++;
            $display("FAIL add_timing: got busy=%0d done_at=%0d required 32/33", nb, lat);
        end
        checks++;
        if (c0 !== 1'b0 || s0 !== 3'b010) begin
            errors++;
            $display("FAIL add_first_slice: got cin=%b sig=%b required 0/010", c0, s0);
        end
        checks++;
        if ({slice_a, slice_b, slice_signal, slice_cin} !== 6'b0) begin
            errors++;
            $display("FAIL done_slice_idle: got %b required 000000", {slice_a, slice_b, slice_signal, slice_cin});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dataOut !== 32'h0000000C) begin
            errors++;
            $display("FAIL done_pulse: got done=%b dataOut=%h required 0/0000000c", done, dataOut);
        end
    endtask

    task automatic test_sub_logic();
        logic [31:0] res; logic z; int nb; int lat; logic [2:0] s0; logic c0;
        run_op(32'd3, 32'd5, 3'b110, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'hFFFFFFFE || z !== 1'b0 || c0 !== 1'b1) begin
            errors++;
            $display("FAIL sub_3_5: got %h zero=%b cin0=%b required fffffffe/0/1", res, z, c0);
        end
        run_op(32'd9, 32'd9, 3'b110, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'h0 || z !== 1'b1) begin
            errors++;
            $display("FAIL sub_9_9: got %h zero=%b required 00000000/1", res, z);
        end
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'hF000F000 || z !== 1'b0) begin
            errors++;
            $display("FAIL and: got %h zero=%b required f000f000/0", res, z);
        end
        run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b001, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'hFFF0FFF0) begin
            errors++;
            $display("FAIL or: got %h required fff0fff0", res);
        end
    endtask

    task automatic test_slt();
        logic [31:0] res; logic z; int nb; int lat; logic [2:0] s0; logic c0;
        logic [31:0] exp_ovf;
`ifdef SLT_OVF_FIX_EN
        exp_ovf = 32'h1;
`else
        exp_ovf = 32'h0;
`endif
        run_op(32'h80000000, 32'h1, 3'b111, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== exp_ovf) begin
            errors++;
            $display("FAIL slt_ovf: got %h required %h", res, exp_ovf);
        end
        run_op(32'd2, 32'd3, 3'b111, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'h1 || z !== 1'b0) begin
            errors++;
            $display("FAIL slt_2_3: got %h zero=%b required 00000001/0", res, z);
        end
        run_op(32'd3, 32'd2, 3'b111, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'h0 || z !== 1'b1) begin
            errors++;
            $display("FAIL slt_3_2: got %h zero=%b required 00000000/1", res, z);
        end
    endtask

    task automatic test_invalid_op();
        logic [31:0] res; logic z; int nb; int lat; logic [2:0] s0; logic c0;
        run_op(32'd4, 32'd6, 3'b011, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'd10 || s0 !== 3'b010 || c0 !== 1'b0) begin
            errors++;
            $display("FAIL invalid_op: got %h sig=%b cin=%b required 0000000a/010/0", res, s0, c0);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        start = 1'b1; dataA = 32'd100; dataB = 32'd23; signal = 3'b010;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (9) begin @(negedge clk); lat++; end
        start = 1'b1; dataA = 32'd1; dataB = 32'd1; signal = 3'b110;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 33 || dataOut !== 32'd123) begin
            errors++;
            $display("FAIL start_ignored: got done_at=%0d dataOut=%h required 33/0000007b", lat, dataOut);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; dataA = 32'd10; dataB = 32'd20; signal = 3'b010;
        @(negedge clk);
        dataA = 32'd7; dataB = 32'd8; signal = 3'b110;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 33 || dataOut !== 32'd30) begin
            errors++;
            $display("FAIL b2b_first: got done_at=%0d dataOut=%h required 33/0000001e", lat, dataOut);
        end
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b done=%b required 1/0", busy, done);
        end
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 33 || dataOut !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL b2b_second: got done_at=%0d dataOut=%h required 33/ffffffff", lat, dataOut);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic z; int nb; int lat; logic [2:0] s0; logic c0;
        logic saw_done;
        @(negedge clk);
        start = 1'b1; dataA = 32'd5; dataB = 32'd7; signal = 3'b010;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, zero} !== 3'b001 || dataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy/done/zero=%b dataOut=%h required 001/00000000",
                     {busy, done, zero}, dataOut);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got activity=%b required 0", saw_done);
        end
        run_op(32'd1, 32'd1, 3'b010, res, z, nb, lat, s0, c0);
        checks++;
        if (res !== 32'd2) begin
            errors++;
            $display("FAIL post_reset_add: got %h required 00000002", res);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_logic();
        test_slt();
        test_invalid_op();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
